// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues sequential PCs to ICache and queues {pc, instr, misalign}
// entries for decode. Redirects flush the queue and discard any in-flight response.
package fetch_unit_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
endpackage

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_misalign
);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] QD = CW'(QDEPTH);

    typedef enum logic {FETCH, WAIT} state_t;

    state_t        state, state_n;
    logic          req_valid, req_valid_n;
    logic [63:0]   req_addr, req_addr_n;
    logic [63:0]   pc, pc_n;
    logic          kill, kill_n;
    logic          halted, halted_n;

    logic [63:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];
    logic          q_mis   [QDEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, cnt_pop, cnt_n;

    logic          outstanding, head_valid, pop;
    logic          push, push_mis, try_issue;
    logic [63:0]   push_pc, cand;
    logic [31:0]   push_instr;
    logic          unused_addr_ok;

    // addr_ok carries no information for a single-outstanding requester
    assign unused_addr_ok = iresp.addr_ok;

    always_comb begin
        ireq.valid = req_valid;
        ireq.addr  = req_addr;
    end

    assign outstanding  = req_valid && (state == FETCH);
    assign head_valid   = (count != '0);
    assign out_valid    = head_valid && !redirect_valid;
    assign out_pc       = head_valid ? q_pc[rd_ptr]    : '0;
    assign out_instr    = head_valid ? q_instr[rd_ptr] : '0;
    assign out_misalign = head_valid ? q_mis[rd_ptr]   : 1'b0;
    assign pop          = out_valid && out_ready;

    always_comb begin
        cnt_pop     = count - CW'(pop);
        pc_n        = pc;
        req_valid_n = req_valid;
        req_addr_n  = req_addr;
        kill_n      = kill;
        halted_n    = halted;
        push        = 1'b0;
        push_pc     = req_addr;
        push_instr  = iresp.data;
        push_mis    = 1'b0;
        cand        = pc;
        try_issue   = 1'b0;

        if (redirect_valid) begin
            pc_n     = redirect_pc;
            halted_n = 1'b0;
            if (outstanding && !iresp.data_ok) begin
                kill_n = 1'b1;
            end else begin
                kill_n    = 1'b0;
                cand      = redirect_pc;
                try_issue = 1'b1;
            end
        end else if (outstanding && iresp.data_ok) begin
            if (kill) begin
                kill_n = 1'b0;
            end else begin
                push = 1'b1;
                pc_n = req_addr + 64'd4;
                cand = req_addr + 64'd4;
            end
            try_issue = 1'b1;
        end else if (!outstanding && !halted) begin
            if (pc[1:0] == 2'b00) begin
                try_issue = 1'b1;
            end else if (cnt_pop < QD) begin
                // Misaligned target: report it as a queue entry instead of a bus request
                push       = 1'b1;
                push_pc    = pc;
                push_instr = '0;
                push_mis   = 1'b1;
                halted_n   = 1'b1;
            end
        end

        cnt_n = redirect_valid ? '0 : cnt_pop + CW'(push);

        if (try_issue) begin
            req_valid_n = !halted_n && (cnt_n < QD) && (cand[1:0] == 2'b00);
            req_addr_n  = cand;
        end

        state_n = req_valid_n ? FETCH : WAIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            req_valid <= 1'b0;
            req_addr  <= RESET_PC;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            halted    <= 1'b0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            state     <= state_n;
            req_valid <= req_valid_n;
            req_addr  <= req_addr_n;
            pc        <= pc_n;
            kill      <= kill_n;
            halted    <= halted_n;
            count     <= cnt_n;
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                if (push) wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !redirect_valid && !reset) begin
            q_pc[wr_ptr]    <= push_pc;
            q_instr[wr_ptr] <= push_instr;
            q_mis[wr_ptr]   <= push_mis;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a scripted ICache model answers requests, directed
// sequences push expected queue entries, and a monitor checks every entry decode accepts.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;

    fetch_unit #(.RESET_PC(64'h8000_0000), .QDEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_misalign   (out_misalign)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   lat = 0;
    int   limit = 0;
    int   granted = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] icache_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic [63:0] pc, input logic mis);
        exp_t e;
        e.pc    = pc;
        e.instr = mis ? 32'h0 : icache_word(pc);
        e.mis   = mis;
        exp_q.push_back(e);
    endtask

    task automatic give(input int n);
        limit = granted + n;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending_entries=%0d required=0", name, exp_q.size());
        end
    endtask

    // ICache model: grants data_ok after `lat` waiting cycles, only while grants remain
    initial begin
        int cnt = 0;
        iresp = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt   = 0;
                iresp = '0;
            end else begin
                if (iresp.data_ok) cnt = 0;
                iresp.data_ok = 1'b0;
                iresp.addr_ok = ireq.valid;
                if (ireq.valid && granted < limit) begin
                    if (cnt >= lat) begin
                        iresp.data_ok = 1'b1;
                        iresp.data    = icache_word(ireq.addr);
                        granted++;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    // Monitor: every accepted head entry must match the oldest expected entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry actual_pc=%h required=no_entry", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("entry_pc", out_pc, e.pc);
                    chk("entry_instr", 64'(out_instr), 64'(e.instr));
                    chk("entry_misalign", 64'(out_misalign), 64'(e.mis));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset values and streaming with same-cycle data_ok
        step(); step(); step();
        chk("rst_ireq_valid", 64'(ireq.valid), 64'd0);
        chk("rst_ireq_addr", ireq.addr, 64'h8000_0000);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_misalign", 64'(out_misalign), 64'd0);
        expect_entry(64'h8000_0000, 1'b0);
        expect_entry(64'h8000_0004, 1'b0);
        expect_entry(64'h8000_0008, 1'b0);
        give(3);
        reset = 1'b0;
        step();
        chk("t1_valid0", 64'(ireq.valid), 64'd1);
        chk("t1_addr0", ireq.addr, 64'h8000_0000);
        chk("t1_outv0", 64'(out_valid), 64'd0);
        step();
        chk("t1_addr1", ireq.addr, 64'h8000_0004);
        chk("t1_outpc0", out_pc, 64'h8000_0000);
        step();
        chk("t1_addr2", ireq.addr, 64'h8000_0008);
        chk("t1_outpc1", out_pc, 64'h8000_0004);
        step();
        chk("t1_addr3_pending", ireq.addr, 64'h8000_000C);
        chk("t1_outpc2", out_pc, 64'h8000_0008);
        wait_drain("t1_drain");

        // Queue fills to QDEPTH, one pop restarts fetch
        out_ready = 1'b0; reset = 1'b1;
        step(); step();
        expect_entry(64'h8000_0000, 1'b0);
        expect_entry(64'h8000_0004, 1'b0);
        expect_entry(64'h8000_0008, 1'b0);
        expect_entry(64'h8000_000C, 1'b0);
        expect_entry(64'h8000_0010, 1'b0);
        give(5);
        reset = 1'b0;
        repeat (7) step();
        chk("t2_full_no_req", 64'(ireq.valid), 64'd0);
        chk("t2_full_outv", 64'(out_valid), 64'd1);
        chk("t2_full_head", out_pc, 64'h8000_0000);
        out_ready = 1'b1;
        chk("t2_pop_cycle_no_req", 64'(ireq.valid), 64'd0);
        step();
        out_ready = 1'b0;
        chk("t2_after_pop_valid", 64'(ireq.valid), 64'd1);
        chk("t2_after_pop_addr", ireq.addr, 64'h8000_0010);
        out_ready = 1'b1;
        wait_drain("t2_drain");

        // Redirect while a slow request is pending
        reset = 1'b1;
        step(); step();
        expect_entry(64'h8000_0000, 1'b0);
        expect_entry(64'h8000_0004, 1'b0);
        give(2);
        reset = 1'b0;
        wait_drain("t3_pre_drain");
        step(); step();
        chk("t3_pending_addr", ireq.addr, 64'h8000_0008);
        lat = 3;
        give(1);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_valid", 64'(ireq.valid), 64'd1);
            chk("t3_hold_addr", ireq.addr, 64'h8000_0008);
            step();
        end
        chk("t3_target_valid", 64'(ireq.valid), 64'd1);
        chk("t3_target_addr", ireq.addr, 64'h8000_1000);
        chk("t3_killed_not_queued", 64'(out_valid), 64'd0);
        lat = 0;
        expect_entry(64'h8000_1000, 1'b0);
        give(1);
        wait_drain("t3_drain");

        // Redirect coinciding with data_ok
        step(); step();
        chk("t4_pending_addr", ireq.addr, 64'h8000_1004);
        give(1);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        step();
        redirect_valid = 1'b0;
        chk("t4_target_valid", 64'(ireq.valid), 64'd1);
        chk("t4_target_addr", ireq.addr, 64'h8000_2000);
        chk("t4_queue_empty", 64'(out_valid), 64'd0);
        step();
        chk("t4_queue_empty2", 64'(out_valid), 64'd0);
        expect_entry(64'h8000_2000, 1'b0);
        give(1);
        wait_drain("t4_drain");

        // Misaligned redirect halts fetch until the next redirect
        out_ready = 1'b0; reset = 1'b1;
        step(); step();
        expect_entry(64'h8000_0002, 1'b1);
        reset = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
        step();
        redirect_valid = 1'b0;
        chk("t5_no_req", 64'(ireq.valid), 64'd0);
        step();
        chk("t5_outv", 64'(out_valid), 64'd1);
        chk("t5_pc", out_pc, 64'h8000_0002);
        chk("t5_mis", 64'(out_misalign), 64'd1);
        chk("t5_instr", 64'(out_instr), 64'd0);
        out_ready = 1'b1;
        wait_drain("t5_drain");
        repeat (4) begin
            chk("t5_halted_no_req", 64'(ireq.valid), 64'd0);
            step();
        end
        chk("t5_halted_empty", 64'(out_valid), 64'd0);
        expect_entry(64'h8000_0100, 1'b0);
        give(1);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        chk("t5_restart_valid", 64'(ireq.valid), 64'd1);
        chk("t5_restart_addr", ireq.addr, 64'h8000_0100);
        wait_drain("t5_restart_drain");

        // Reset mid-transaction with the queue half full
        out_ready = 1'b0; reset = 1'b1;
        step(); step();
        give(2);
        reset = 1'b0;
        repeat (6) step();
        chk("t6_pre_outv", 64'(out_valid), 64'd1);
        chk("t6_pre_head", out_pc, 64'h8000_0000);
        chk("t6_pre_pending", ireq.addr, 64'h8000_0008);
        reset = 1'b1;
        step();
        chk("t6_rst_ireq_valid", 64'(ireq.valid), 64'd0);
        chk("t6_rst_ireq_addr", ireq.addr, 64'h8000_0000);
        chk("t6_rst_outv", 64'(out_valid), 64'd0);
        chk("t6_rst_out_pc", out_pc, 64'd0);
        chk("t6_rst_out_instr", 64'(out_instr), 64'd0);
        chk("t6_rst_out_mis", 64'(out_misalign), 64'd0);
        expect_entry(64'h8000_0000, 1'b0);
        give(1);
        out_ready = 1'b1;
        reset = 1'b0;
        step();
        chk("t6_first_valid", 64'(ireq.valid), 64'd1);
        chk("t6_first_addr", ireq.addr, 64'h8000_0000);
        wait_drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
